// File: rtl/rf_scoreboard_pkg.sv
// Shared CPU package: next-PC selects, forwarding-select encodings and the
// in-flight slot record used by the register-file scoreboard.
package rf_scoreboard_pkg;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JAL  = 2'd2;
  localparam logic [1:0] NPC_JALR = 2'd3;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] wR;
    logic       load;
  } slot_t;

  function automatic logic slot_hit(slot_t s, logic [4:0] r);
    return s.valid && (s.wR == r);
  endfunction

  // Youngest matching producer wins: EX before MEM before WB.
  function automatic fwd_sel_t fwd_pick(logic en, logic [4:0] r,
                                        slot_t ex, slot_t mem, slot_t wb);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (en) begin
      if (slot_hit(ex, r))       sel = FWD_EX;
      else if (slot_hit(mem, r)) sel = FWD_MEM;
      else if (slot_hit(wb, r))  sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/rf_scoreboard_if.sv
// ID-stage request/response bundle between the decode stage and the scoreboard.
interface rf_scoreboard_if;
    logic       id_valid;
    logic       id_rf_we;
    logic       id_load;
    logic [4:0] id_wR;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_re1;
    logic       id_re2;
    logic       flush;
    logic       stall;
    logic [1:0] rs1_fwd;
    logic [1:0] rs2_fwd;
    logic [31:0] pend_vec;

    modport master (
        output id_valid, id_rf_we, id_load, id_wR, id_rs1, id_rs2,
               id_re1, id_re2, flush,
        input  stall, rs1_fwd, rs2_fwd, pend_vec
    );

    modport slave (
        input  id_valid, id_rf_we, id_load, id_wR, id_rs1, id_rs2,
               id_re1, id_re2, flush,
        output stall, rs1_fwd, rs2_fwd, pend_vec
    );
endinterface

// File: rtl/rf_scoreboard_sb_cnt.sv
// Per-register outstanding-write counter; pend_o is high while any write
// to this register is still in flight.
module sb_cnt (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic dec_i,
    output logic pend_o
);
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i)      cnt_d = cnt_q + 2'd1;
        else if (dec_i && !inc_i) cnt_d = cnt_q - 2'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign pend_o = (cnt_q != '0);
endmodule

// File: rtl/rf_scoreboard.sv
// Register-file hazard scoreboard tracking EX/MEM/WB writes.
// Define SB_FWD_EN for forwarding with load-use stall; default is a full interlock.
module rf_scoreboard (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    rf_scoreboard_if.slave sb
);
    import rf_scoreboard_pkg::*;

    slot_t       ex_q, mem_q, wb_q, ex_d;
    logic [31:0] pend;
    logic        ins_valid, stall, rs1_en, rs2_en;
    fwd_sel_t    fwd1, fwd2;
    logic        unused_load;

    always_comb begin
        rs1_en = sb.id_re1 && (sb.id_rs1 != '0);
        rs2_en = sb.id_re2 && (sb.id_rs2 != '0);
        fwd1   = FWD_RF;
        fwd2   = FWD_RF;
        stall  = 1'b0;
`ifdef SB_FWD_EN
        fwd1  = fwd_pick(rs1_en, sb.id_rs1, ex_q, mem_q, wb_q);
        fwd2  = fwd_pick(rs2_en, sb.id_rs2, ex_q, mem_q, wb_q);
        stall = sb.id_valid && !sb.flush && ex_q.load &&
                ((rs1_en && slot_hit(ex_q, sb.id_rs1)) ||
                 (rs2_en && slot_hit(ex_q, sb.id_rs2)));
`else
        stall = sb.id_valid && !sb.flush &&
                ((rs1_en && (pend[sb.id_rs1] || slot_hit(ex_q, sb.id_rs1) ||
                             slot_hit(mem_q, sb.id_rs1) || slot_hit(wb_q, sb.id_rs1))) ||
                 (rs2_en && (pend[sb.id_rs2] || slot_hit(ex_q, sb.id_rs2) ||
                             slot_hit(mem_q, sb.id_rs2) || slot_hit(wb_q, sb.id_rs2))));
`endif
        // Flush outranks stall: a killed instruction never stalls nor inserts.
        ins_valid = sb.id_valid && sb.id_rf_we && (sb.id_wR != '0) && !stall && !sb.flush;
        ex_d = '0;
        if (ins_valid) ex_d = '{valid: 1'b1, wR: sb.id_wR, load: sb.id_load};
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    assign pend[0] = 1'b0;

    for (genvar r = 1; r < 32; r++) begin : g_cnt
        sb_cnt u_cnt (
            .clk_i  (cpu_clk),
            .rst_ni (cpu_rst),
            .inc_i  (ins_valid && (sb.id_wR == 5'(r))),
            .dec_i  (wb_q.valid && (wb_q.wR == 5'(r))),
            .pend_o (pend[r])
        );
    end

    assign unused_load = ex_q.load ^ mem_q.load ^ wb_q.load;

    assign sb.stall    = stall;
    assign sb.rs1_fwd  = fwd1;
    assign sb.rs2_fwd  = fwd2;
    assign sb.pend_vec = pend;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed and randomized bench for rf_scoreboard against an age-based
// model of in-flight register writes (honours SB_FWD_EN).
module tb_rf_scoreboard;
    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b0;
    int   ncmp = 0;
    int   nfail = 0;
    int   cyc = 0;

    typedef struct {int r; bit ld; int t;} wr_t;
    wr_t q[$];

    rf_scoreboard_if sb();

    rf_scoreboard dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .sb      (sb)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Age 0 = EX, 1 = MEM, 2 = WB; -1 when no write to r is outstanding.
    function automatic int youngest_age(int r);
        int best = -1;
        foreach (q[i]) begin
            int a = cyc - q[i].t;
            if (q[i].r == r && (best < 0 || a < best)) best = a;
        end
        return best;
    endfunction

    function automatic bit src_blocks(bit en, int s);
        if (!en || s == 0) return 0;
`ifdef SB_FWD_EN
        foreach (q[i]) if (q[i].r == s && q[i].ld && cyc - q[i].t == 0) return 1;
        return 0;
`else
        return youngest_age(s) >= 0;
`endif
    endfunction

    function automatic bit m_stall();
        if (!sb.id_valid || sb.flush) return 0;
        return src_blocks(sb.id_re1, int'(sb.id_rs1)) || src_blocks(sb.id_re2, int'(sb.id_rs2));
    endfunction

    function automatic logic [1:0] m_fwd(bit en, int s);
`ifdef SB_FWD_EN
        int a;
        if (!en || s == 0) return 2'b00;
        a = youngest_age(s);
        return (a < 0) ? 2'b00 : 2'(a + 1);
`else
        return (en && s == 0) ? 2'b00 : 2'b00;
`endif
    endfunction

    function automatic logic [31:0] m_pend();
        logic [31:0] v = '0;
        foreach (q[i]) v[q[i].r] = 1'b1;
        return v;
    endfunction

    task automatic drive(input bit v, we, ld, input int wr, input bit e1, input int s1,
                         input bit e2, input int s2, input bit fl);
        sb.id_valid = v;  sb.id_rf_we = we; sb.id_load = ld; sb.id_wR = 5'(wr);
        sb.id_re1 = e1;   sb.id_rs1 = 5'(s1);
        sb.id_re2 = e2;   sb.id_rs2 = 5'(s2);
        sb.flush = fl;
        #1;
        chk("stall", {31'b0, sb.stall}, {31'b0, m_stall()});
        chk("rs1_fwd", {30'b0, sb.rs1_fwd}, {30'b0, m_fwd(e1, s1)});
        chk("rs2_fwd", {30'b0, sb.rs2_fwd}, {30'b0, m_fwd(e2, s2)});
        chk("pend_vec", sb.pend_vec, m_pend());
    endtask

    task automatic tick();
        bit ins;
        ins = sb.id_valid && sb.id_rf_we && sb.id_wR != 0 && !m_stall() && !sb.flush;
        @(posedge cpu_clk);
        cyc++;
        for (int i = q.size() - 1; i >= 0; i--) if (cyc - q[i].t > 2) q.delete(i);
        if (ins) q.push_back('{r: int'(sb.id_wR), ld: sb.id_load, t: cyc});
        @(negedge cpu_clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); end
    endtask

    // Reset pulled low between edges must clear pending state at once.
    task automatic rst_mid();
        #2 cpu_rst = 1'b0;
        #1;
        chk("rst_pend", sb.pend_vec, 32'h0);
        chk("rst_stall", {31'b0, sb.stall}, 32'h0);
        chk("rst_fwd", {28'b0, sb.rs1_fwd, sb.rs2_fwd}, 32'h0);
        @(posedge cpu_clk);
        q.delete();
        cyc++;
        @(negedge cpu_clk);
        cpu_rst = 1'b1;
    endtask

    initial begin
        sb.id_valid = 0; sb.id_rf_we = 0; sb.id_load = 0; sb.id_wR = '0;
        sb.id_re1 = 0; sb.id_rs1 = '0; sb.id_re2 = 0; sb.id_rs2 = '0; sb.flush = 0;
        #1;
        chk("reset_pend", sb.pend_vec, 32'h0);
        chk("reset_stall", {31'b0, sb.stall}, 32'h0);
        chk("reset_fwd", {28'b0, sb.rs1_fwd, sb.rs2_fwd}, 32'h0);
        @(negedge cpu_clk);
        cpu_rst = 1'b1;

        // add r5, then a reader of r5 in the following two cycles
        drive(1, 1, 0, 5, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 1, 5, 0, 0, 0);
`ifdef SB_FWD_EN
        chk("r5_ex_fwd", {30'b0, sb.rs1_fwd}, 32'h1);
        chk("r5_ex_stall", {31'b0, sb.stall}, 32'h0);
`else
        chk("r5_ex_stall", {31'b0, sb.stall}, 32'h1);
`endif
        tick();
        drive(1, 0, 0, 0, 1, 5, 0, 0, 0);
`ifdef SB_FWD_EN
        chk("r5_mem_fwd", {30'b0, sb.rs1_fwd}, 32'h2);
`else
        chk("r5_mem_stall", {31'b0, sb.stall}, 32'h1);
`endif
        tick(); idle(3);

        // ld r7 followed by a reader of r7 on rs2
        drive(1, 1, 1, 7, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 1, 7, 0);
        chk("ld_use_stall", {31'b0, sb.stall}, 32'h1);
        chk("ld_pend7_ex", {31'b0, sb.pend_vec[7]}, 32'h1);
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 7, 0);
`ifdef SB_FWD_EN
        chk("ld_one_stall", {31'b0, sb.stall}, 32'h0);
        chk("ld_mem_fwd", {30'b0, sb.rs2_fwd}, 32'h2);
`else
        chk("ld_interlock", {31'b0, sb.stall}, 32'h1);
`endif
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ld_pend7_wb", {31'b0, sb.pend_vec[7]}, 32'h1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ld_pend7_retired", {31'b0, sb.pend_vec[7]}, 32'h0);
        tick(); idle(1);

        // r3 in EX and WB simultaneously
        drive(1, 1, 0, 3, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 9, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 3, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 1, 3, 0, 0, 0);
`ifdef SB_FWD_EN
        chk("r3_youngest", {30'b0, sb.rs1_fwd}, 32'h1);
`else
        chk("r3_stall", {31'b0, sb.stall}, 32'h1);
`endif
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r3_second_write_pending", {31'b0, sb.pend_vec[3]}, 32'h1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r3_drained", {31'b0, sb.pend_vec[3]}, 32'h0);
        tick();

        // load-use with flush in the same cycle
        drive(1, 1, 1, 7, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 8, 1, 7, 0, 0, 1);
        chk("flush_no_stall", {31'b0, sb.stall}, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_no_insert", sb.pend_vec, 32'h0000_0080);
        tick(); idle(2);

        // writes and reads of r0
        drive(1, 1, 0, 0, 1, 0, 1, 0, 0);
        chk("r0_fwd", {28'b0, sb.rs1_fwd, sb.rs2_fwd}, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_no_insert", sb.pend_vec, 32'h0);
        tick();

        // reset mid-flight with three slots valid, then r5 interlock
        drive(1, 1, 0, 5, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 6, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 1, 7, 0, 0, 0, 0, 0); tick();
        chk("pre_rst_pend", sb.pend_vec, 32'h0000_00E0);
        rst_mid();
        drive(1, 1, 0, 5, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 1, 5, 0, 0, 0);
`ifndef SB_FWD_EN
        chk("r5_pend_stall", {31'b0, sb.stall}, 32'h1);
`endif
        for (int i = 0; i < 6 && sb.stall; i++) begin
            tick();
            drive(1, 0, 0, 0, 1, 5, 0, 0, 0);
        end
        chk("r5_stall_clears", {31'b0, sb.stall}, 32'h0);
        tick();

        // randomized traffic over a narrow register window to force hazards
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 7),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                  $urandom_range(0, 7) == 0);
            tick();
            if ($urandom_range(0, 59) == 0) rst_mid();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
